operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  ID->EX operand stage, directly downstream of the register file.
//  - Drives the regfile read selects.
//  - Resolves RAW hazards by bypass or stall.
//  - Holds the ID/EX pipeline register behind a valid/ready handshake.
//  Feeds the ALU/EX stage with final operand values.
// PARAMETERS
//  XLEN    32  data width
//  CTRL_W  16  width of opaque decoded-control bundle passed through to EX
// PORTS
//  clk             in   1       clock; all state updates on posedge
//  rst             in   1       synchronous reset, active-high
//  flush           in   1       kill ID/EX contents (branch/trap redirect)
//  id_valid        in   1       decoded instruction offered
//  id_ready        out  1       stage accepts id_* this cycle
//  id_rs1, id_rs2  in   5       source register indices
//  id_rd           in   5       destination index
//  id_rd_wen       in   1       instruction writes rd
//  id_is_load      in   1       instruction is a load
//  id_pc, id_imm   in   XLEN    pass-through
//  id_ctrl         in   CTRL_W  pass-through
//  rf_regA_sel     out  5       = id_rs1 (combinational)
//  rf_regB_sel     out  5       = id_rs2 (combinational)
//  rf_regA_i       in   XLEN    regfile read data A (combinational read)
//  rf_regB_i       in   XLEN    regfile read data B (combinational read)
//  fwd_ex_result   in   XLEN    ALU result of instr now held in ID/EX (comb.)
//  fwd_mem_rd      in   5       EX/MEM destination index
//  fwd_mem_wen     in   1       EX/MEM destination write enable
//  fwd_mem_is_load in   1       EX/MEM instruction is a load
//  fwd_mem_result  in   XLEN    EX/MEM result
//  fwd_wb_rd       in   5       MEM/WB destination index (regfile write port)
//  fwd_wb_wen      in   1       MEM/WB write enable (regfile write port)
//  fwd_wb_result   in   XLEN    MEM/WB write data (regfile write port)
//  ex_valid        out  1       ID/EX register holds a live instruction
//  ex_ready        in   1       EX consumes ID/EX this cycle
//  ex_op_a, ex_op_b out XLEN    resolved operands
//  ex_rd, ex_rd_wen, ex_is_load, ex_pc, ex_imm, ex_ctrl  out  registered pass-through
// BEHAVIOUR
//  - Reset: ex_valid=0; all ex_* data outputs = 0.
//  - id_ready = !rst && !flush && !stall && (!ex_valid || ex_ready).
//  - Accept (id_valid && id_ready): ID/EX loads all fields; ex_valid=1 next cycle. Latency 1 cycle.
//  - No accept but ex_ready: ex_valid=0 (bubble).
//  - No accept and !ex_ready: hold every output unchanged.
//  - flush: ex_valid=0 next cycle regardless of ex_ready or stall. Flush wins over accept.
//  - "Match" for a source rs: rs!=0 and producer valid, wen=1, rd==rs.
//    EX producer = ex_valid && ex_rd_wen && ex_rd==rs.
//  - Operand priority, youngest first: EX (fwd_ex_result) > MEM (fwd_mem_result) > WB (fwd_wb_result) > regfile.
//  - rs==0: operand is always 0; no forwarding, no stall.
//  - WB bypass is mandatory: the regfile write lands at the same posedge, so regfile read data is stale.
//  - stall (FORWARD_EN defined) = any used rs matches EX with ex_is_load, or MEM with fwd_mem_is_load.
//  - Both rs1 and rs2 are treated as used; unused-source decode is out of scope.
//  - During a stall, the registered ID/EX slot drains as a bubble when ex_ready=1.
//  - Reset mid-operation: in-flight instruction discarded; id_ready=0 while rst=1.
// CONFIGURATION
//  OPFETCH_FORWARD_EN defined:
//   - Full bypass network as above.
//   - Stalls only on load-use.
//  OPFETCH_FORWARD_EN undefined:
//   - No bypass muxes; operands come from the regfile only.
//   - stall = any rs matches EX, MEM or WB.
//   - A dependent instruction waits until the producer has fully retired.
// STRUCTURE
//  Package riscv_pkg:
//   - XLEN and reg_idx_t (logic [4:0]).
//   - ctrl_t (CTRL_W bundle).
//   - fwd_sel_e {FWD_RF, FWD_WB, FWD_MEM, FWD_EX, FWD_ZERO}.
//  Sub-module hazard_fwd_unit:
//   - Combinational; one instance per source operand.
//   - Inputs: rs, producer tags, producer data.
//   - Outputs: resolved operand, stall_req.
//  operand_fetch: instantiates two hazard_fwd_unit, then ORs stall_req, then the handshake, then the ID/EX register.
// TESTING
//  - Reset: rst=1 for 2 cycles, id_valid=1
//    -> ex_valid=0, id_ready=0, ex_op_a=0.
//  - Regfile read: x5=0x1234 in regfile, no producers; accept rs1=5, rs2=0
//    -> next cycle ex_op_a=0x1234, ex_op_b=0.
//  - WB bypass: fwd_wb rd=7, data 0xAAAA5555, wen=1; same cycle accept rs1=7
//    -> ex_op_a=0xAAAA5555.
//  - Priority: EX rd=3 (fwd_ex_result=1), MEM rd=3 (=2), WB rd=3 (=3); rs2=3
//    -> ex_op_b=1 with FORWARD_EN.
//  - Priority, FORWARD_EN undefined: same setup
//    -> stall until all three clear.
//  - Load-use: ex holds load rd=9; accept attempt rs1=9
//    -> id_ready=0 one cycle, bubble into EX.
//    -> Next cycle MEM is_load stalls again.
//    -> Third cycle accept, WB bypass value.
//  - Flush/backpressure: ex_ready=0 for 3 cycles
//    -> ex_* held, id_ready=0.
//    -> Then flush=1 gives ex_valid=0 next cycle.
//  - Write to x0: WB rd=0 wen=1 data 0xFFFF; rs1=0
//    -> ex_op_a=0, no stall.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the ID->EX operand stage.
//   XLEN / CTRL_W : data width and opaque decoded-control width
//   reg_idx_t     : architectural register index
//   xword_t       : XLEN-wide data word
//   ctrl_t        : decoded-control bundle carried to EX untouched
//   fwd_sel_e     : operand source chosen by the bypass network
//   idex_t        : payload of the ID/EX pipeline register
//   producer_match: "rs is produced by this in-flight instruction"
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  typedef logic [4:0]        reg_idx_t;
  typedef logic [XLEN-1:0]   xword_t;
  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic [2:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM,
    FWD_EX,
    FWD_ZERO
  } fwd_sel_e;

  typedef struct packed {
    reg_idx_t rd;
    logic     rd_wen;
    logic     is_load;
    xword_t   pc;
    xword_t   imm;
    ctrl_t    ctrl;
    xword_t   op_a;
    xword_t   op_b;
  } idex_t;

  // x0 is hard-wired to zero, so it never has a producer.
  function automatic logic producer_match(input reg_idx_t rs,
                                          input logic     valid,
                                          input logic     wen,
                                          input reg_idx_t rd);
    return (rs != '0) && valid && wen && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Per-source hazard detection and operand resolution (purely combinational).
// Configuration macro: OPFETCH_FORWARD_EN
//   defined   : bypass EX > MEM > WB > regfile; stall only on load-use
//   undefined : regfile only; stall while any in-flight producer matches
// Ports:
//   rs                         source register index
//   ex_valid/ex_wen/ex_is_load/ex_rd/ex_result      producer held in ID/EX
//   mem_wen/mem_is_load/mem_rd/mem_result           producer in EX/MEM
//   wb_wen/wb_rd/wb_result                          producer on regfile write port
//   rf_data                    regfile read data for rs
//   operand                    resolved operand value
//   stall_req                  this source cannot be resolved this cycle
module hazard_fwd_unit
  import riscv_pkg::*;
(
  input  reg_idx_t rs,
  input  logic     ex_valid,
  input  logic     ex_wen,
  input  logic     ex_is_load,
  input  reg_idx_t ex_rd,
  input  xword_t   ex_result,
  input  logic     mem_wen,
  input  logic     mem_is_load,
  input  reg_idx_t mem_rd,
  input  xword_t   mem_result,
  input  logic     wb_wen,
  input  reg_idx_t wb_rd,
  input  xword_t   wb_result,
  input  xword_t   rf_data,
  output xword_t   operand,
  output logic     stall_req
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // MEM and WB stage registers carry no separate valid; a bubble has wen=0.
  assign ex_hit  = producer_match(rs, ex_valid, ex_wen,  ex_rd);
  assign mem_hit = producer_match(rs, 1'b1,     mem_wen, mem_rd);
  assign wb_hit  = producer_match(rs, 1'b1,     wb_wen,  wb_rd);

`ifdef OPFETCH_FORWARD_EN
  fwd_sel_e sel;

  // Youngest producer wins. WB must be bypassed because the regfile write
  // lands on the same edge that captures this operand.
  always_comb begin
    sel = FWD_RF;
    if (rs == '0) begin
      sel = FWD_ZERO;
    end else if (ex_hit) begin
      sel = FWD_EX;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    operand = rf_data;
    case (sel)
      FWD_ZERO: operand = '0;
      FWD_EX:   operand = ex_result;
      FWD_MEM:  operand = mem_result;
      FWD_WB:   operand = wb_result;
      default:  operand = rf_data;
    endcase
  end

  // Load data is not available from EX or from the EX/MEM result bus, so a
  // matching load in either stage forces a wait (conservatively, even when a
  // younger non-load producer would also match).
  assign stall_req = (ex_hit && ex_is_load) || (mem_hit && mem_is_load);
`else
  assign operand   = (rs == '0) ? '0 : rf_data;
  assign stall_req = ex_hit || mem_hit || wb_hit;

  // Bypass data and load flags have no consumer without the bypass network.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_result, mem_result, wb_result,
                               ex_is_load, mem_is_load};
`endif

endmodule

// File: rtl/operand_fetch.sv
// ID->EX operand stage: drives regfile read selects, resolves RAW hazards by
// bypass or stall, and holds the ID/EX register behind a valid/ready handshake.
// Configuration macro: OPFETCH_FORWARD_EN (full bypass network when defined;
// regfile-only operands with stall-until-retire when undefined).
// Ports:
//   clk, rst (sync, active-high), flush (kill ID/EX contents)
//   id_*            decoded instruction offered with id_valid / id_ready
//   rf_regA/B_sel   regfile read selects (= id_rs1 / id_rs2)
//   rf_regA/B_i     regfile read data (combinational read)
//   fwd_ex_result   ALU result of the instruction now held in ID/EX
//   fwd_mem_*       EX/MEM producer tags and result
//   fwd_wb_*        MEM/WB producer (regfile write port)
//   ex_valid/ex_ready  ID/EX handshake toward EX
//   ex_op_a/b       resolved operands; ex_rd..ex_ctrl registered pass-through
module operand_fetch
  import riscv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     id_valid,
  output logic     id_ready,
  input  reg_idx_t id_rs1,
  input  reg_idx_t id_rs2,
  input  reg_idx_t id_rd,
  input  logic     id_rd_wen,
  input  logic     id_is_load,
  input  xword_t   id_pc,
  input  xword_t   id_imm,
  input  ctrl_t    id_ctrl,
  output reg_idx_t rf_regA_sel,
  output reg_idx_t rf_regB_sel,
  input  xword_t   rf_regA_i,
  input  xword_t   rf_regB_i,
  input  xword_t   fwd_ex_result,
  input  reg_idx_t fwd_mem_rd,
  input  logic     fwd_mem_wen,
  input  logic     fwd_mem_is_load,
  input  xword_t   fwd_mem_result,
  input  reg_idx_t fwd_wb_rd,
  input  logic     fwd_wb_wen,
  input  xword_t   fwd_wb_result,
  output logic     ex_valid,
  input  logic     ex_ready,
  output xword_t   ex_op_a,
  output xword_t   ex_op_b,
  output reg_idx_t ex_rd,
  output logic     ex_rd_wen,
  output logic     ex_is_load,
  output xword_t   ex_pc,
  output xword_t   ex_imm,
  output ctrl_t    ex_ctrl
);

  logic     valid_reg;
  logic     valid_next;
  idex_t    idex_reg;
  idex_t    idex_next;

  reg_idx_t src_rs    [2];
  xword_t   src_rf    [2];
  xword_t   src_op    [2];
  logic     src_stall [2];

  logic     stall;
  logic     accept;

  assign rf_regA_sel = id_rs1;
  assign rf_regB_sel = id_rs2;

  assign src_rs[0] = id_rs1;
  assign src_rs[1] = id_rs2;
  assign src_rf[0] = rf_regA_i;
  assign src_rf[1] = rf_regB_i;

  // One resolver per source operand; both sources are treated as used.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      hazard_fwd_unit u_hazard (
        .rs          (src_rs[gi]),
        .ex_valid    (valid_reg),
        .ex_wen      (idex_reg.rd_wen),
        .ex_is_load  (idex_reg.is_load),
        .ex_rd       (idex_reg.rd),
        .ex_result   (fwd_ex_result),
        .mem_wen     (fwd_mem_wen),
        .mem_is_load (fwd_mem_is_load),
        .mem_rd      (fwd_mem_rd),
        .mem_result  (fwd_mem_result),
        .wb_wen      (fwd_wb_wen),
        .wb_rd       (fwd_wb_rd),
        .wb_result   (fwd_wb_result),
        .rf_data     (src_rf[gi]),
        .operand     (src_op[gi]),
        .stall_req   (src_stall[gi])
      );
    end
  endgenerate

  assign stall    = src_stall[0] || src_stall[1];
  assign id_ready = !rst && !flush && !stall && (!valid_reg || ex_ready);
  assign accept   = id_valid && id_ready;

  // Flush beats everything; an un-replaced slot drains when EX takes it;
  // otherwise the whole register holds (payload is left alone on flush).
  always_comb begin
    valid_next = valid_reg;
    idex_next  = idex_reg;
    if (flush) begin
      valid_next = 1'b0;
    end else if (accept) begin
      valid_next        = 1'b1;
      idex_next.rd      = id_rd;
      idex_next.rd_wen  = id_rd_wen;
      idex_next.is_load = id_is_load;
      idex_next.pc      = id_pc;
      idex_next.imm     = id_imm;
      idex_next.ctrl    = id_ctrl;
      idex_next.op_a    = src_op[0];
      idex_next.op_b    = src_op[1];
    end else if (ex_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      idex_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      idex_reg  <= idex_next;
    end
  end

  assign ex_valid   = valid_reg;
  assign ex_op_a    = idex_reg.op_a;
  assign ex_op_b    = idex_reg.op_b;
  assign ex_rd      = idex_reg.rd;
  assign ex_rd_wen  = idex_reg.rd_wen;
  assign ex_is_load = idex_reg.is_load;
  assign ex_pc      = idex_reg.pc;
  assign ex_imm     = idex_reg.imm;
  assign ex_ctrl    = idex_reg.ctrl;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch. Expectations follow the build:
// OPFETCH_FORWARD_EN defined -> bypass network; undefined -> stall-until-retire.
// A small regfile model supplies combinational read data and takes the WB
// write at the clock edge, so regfile data is stale during the WB cycle.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rd_wen, id_is_load;
  logic [31:0] id_pc, id_imm;
  logic [15:0] id_ctrl;
  logic [4:0]  rf_regA_sel, rf_regB_sel;
  logic [31:0] rf_regA_i, rf_regB_i;
  logic [31:0] fwd_ex_result;
  logic [4:0]  fwd_mem_rd;
  logic        fwd_mem_wen, fwd_mem_is_load;
  logic [31:0] fwd_mem_result;
  logic [4:0]  fwd_wb_rd;
  logic        fwd_wb_wen;
  logic [31:0] fwd_wb_result;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_op_a, ex_op_b;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen, ex_is_load;
  logic [31:0] ex_pc, ex_imm;
  logic [15:0] ex_ctrl;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_rd_wen       (id_rd_wen),
    .id_is_load      (id_is_load),
    .id_pc           (id_pc),
    .id_imm          (id_imm),
    .id_ctrl         (id_ctrl),
    .rf_regA_sel     (rf_regA_sel),
    .rf_regB_sel     (rf_regB_sel),
    .rf_regA_i       (rf_regA_i),
    .rf_regB_i       (rf_regB_i),
    .fwd_ex_result   (fwd_ex_result),
    .fwd_mem_rd      (fwd_mem_rd),
    .fwd_mem_wen     (fwd_mem_wen),
    .fwd_mem_is_load (fwd_mem_is_load),
    .fwd_mem_result  (fwd_mem_result),
    .fwd_wb_rd       (fwd_wb_rd),
    .fwd_wb_wen      (fwd_wb_wen),
    .fwd_wb_result   (fwd_wb_result),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_op_a         (ex_op_a),
    .ex_op_b         (ex_op_b),
    .ex_rd           (ex_rd),
    .ex_rd_wen       (ex_rd_wen),
    .ex_is_load      (ex_is_load),
    .ex_pc           (ex_pc),
    .ex_imm          (ex_imm),
    .ex_ctrl         (ex_ctrl)
  );

  // Regfile model: x0 reads 0; x5 preloaded to 0x1234 during reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      rf[5] <= 32'h0000_1234;
    end else if (fwd_wb_wen && fwd_wb_rd != 5'd0) begin
      rf[fwd_wb_rd] <= fwd_wb_result;
    end
  end

  always_comb begin
    rf_regA_i = (rf_regA_sel == 5'd0) ? 32'h0 : rf[rf_regA_sel];
    rf_regB_i = (rf_regB_sel == 5'd0) ? 32'h0 : rf[rf_regB_sel];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_producers();
    fwd_ex_result   = 32'h0;
    fwd_mem_rd      = 5'd0;
    fwd_mem_wen     = 1'b0;
    fwd_mem_is_load = 1'b0;
    fwd_mem_result  = 32'h0;
    fwd_wb_rd       = 5'd0;
    fwd_wb_wen      = 1'b0;
    fwd_wb_result   = 32'h0;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [31:0] pc);
    id_valid   = 1'b1;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_rd      = rd;
    id_rd_wen  = wen;
    id_is_load = ld;
    id_pc      = pc;
    id_imm     = pc + 32'h4;
    id_ctrl    = {11'h0, rd};
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    clear_producers();
    offer(5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 32'h40);
    tick();
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid: got %b expected 0", ex_valid);
    else pass_cnt++;
    total_cnt++;
    if (id_ready !== 1'b0) $display("FAIL reset_id_ready: got %b expected 0", id_ready);
    else pass_cnt++;
    total_cnt++;
    if (ex_op_a !== 32'h0) $display("FAIL reset_op_a: got %h expected 0", ex_op_a);
    else pass_cnt++;
    total_cnt++;
    if (ex_pc !== 32'h0) $display("FAIL reset_pc: got %h expected 0", ex_pc);
    else pass_cnt++;
    rst = 1'b0;
    id_valid = 1'b0;
    tick();
    $display("[tb] reset done");
  endtask

  task automatic test_regfile_read();
    offer(5'd5, 5'd0, 5'd10, 1'b1, 1'b0, 32'h100);
    #1;
    total_cnt++;
    if (id_ready !== 1'b1) $display("FAIL rf_id_ready: got %b expected 1", id_ready);
    else pass_cnt++;
    tick();
    id_valid = 1'b0;
    total_cnt++;
    if (ex_valid !== 1'b1) $display("FAIL rf_ex_valid: got %b expected 1", ex_valid);
    else pass_cnt++;
    total_cnt++;
    if (ex_op_a !== 32'h1234) $display("FAIL rf_op_a: got %h expected 00001234", ex_op_a);
    else pass_cnt++;
    total_cnt++;
    if (ex_op_b !== 32'h0) $display("FAIL rf_op_b: got %h expected 0", ex_op_b);
    else pass_cnt++;
    total_cnt++;
    if (ex_rd !== 5'd10 || ex_pc !== 32'h100 || ex_imm !== 32'h104 || ex_ctrl !== 16'h000A)
      $display("FAIL rf_passthru: got rd=%0d pc=%h imm=%h ctrl=%h expected rd=10 pc=100 imm=104 ctrl=000a",
               ex_rd, ex_pc, ex_imm, ex_ctrl);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0) $display("FAIL rf_bubble: got %b expected 0", ex_valid);
    else pass_cnt++;
    $display("[tb] regfile read rs1=5 -> op_a=%h", 32'h1234);
  endtask

  task automatic test_wb_bypass();
    fwd_wb_rd = 5'd7; fwd_wb_wen = 1'b1; fwd_wb_result = 32'hAAAA_5555;
    offer(5'd7, 5'd0, 5'd11, 1'b1, 1'b0, 32'h110);
    #1;
`ifdef OPFETCH_FORWARD_EN
    total_cnt++;
    if (id_ready !== 1'b1) $display("FAIL wb_id_ready: got %b expected 1", id_ready);
    else pass_cnt++;
    tick();
    clear_producers();
`else
    total_cnt++;
    if (id_ready !== 1'b0) $display("FAIL wb_stall: got %b expected 0", id_ready);
    else pass_cnt++;
    tick();
    clear_producers();
    #1;
    total_cnt++;
    if (id_ready !== 1'b1) $display("FAIL wb_retired_ready: got %b expected 1", id_ready);
    else pass_cnt++;
    tick();
`endif
    id_valid = 1'b0;
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_op_a !== 32'hAAAA_5555)
      $display("FAIL wb_op_a: got valid=%b op_a=%h expected valid=1 op_a=aaaa5555", ex_valid, ex_op_a);
    else pass_cnt++;
    tick();
    $display("[tb] wb bypass rs1=7 -> op_a=%h", 32'hAAAA_5555);
  endtask

  task automatic test_priority();
    // Producer of x3 enters ID/EX.
    offer(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'h120);
    tick();
    fwd_ex_result = 32'd1;
    fwd_mem_rd = 5'd3; fwd_mem_wen = 1'b1; fwd_mem_result = 32'd2;
    fwd_wb_rd  = 5'd3; fwd_wb_wen  = 1'b1; fwd_wb_result  = 32'd3;
    offer(5'd0, 5'd3, 5'd12, 1'b1, 1'b0, 32'h124);
    #1;
`ifdef OPFETCH_FORWARD_EN
    total_cnt++;
    if (id_ready !== 1'b1) $display("FAIL prio_id_ready: got %b expected 1", id_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_op_b !== 32'd1 || ex_rd !== 5'd12)
      $display("FAIL prio_op_b: got op_b=%h rd=%0d expected op_b=1 rd=12", ex_op_b, ex_rd);
    else pass_cnt++;
`else
    total_cnt++;
    if (id_ready !== 1'b0) $display("FAIL prio_stall_ex: got %b expected 0", id_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0) $display("FAIL prio_bubble: got %b expected 0", ex_valid);
    else pass_cnt++;
    total_cnt++;
    if (id_ready !== 1'b0) $display("FAIL prio_stall_mem: got %b expected 0", id_ready);
    else pass_cnt++;
    fwd_mem_wen = 1'b0;
    #1;
    total_cnt++;
    if (id_ready !== 1'b0) $display("FAIL prio_stall_wb: got %b expected 0", id_ready);
    else pass_cnt++;
    tick();
    fwd_wb_wen = 1'b0;
    #1;
    total_cnt++;
    if (id_ready !== 1'b1) $display("FAIL prio_release: got %b expected 1", id_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_op_b !== 32'd3)
      $display("FAIL prio_op_b: got valid=%b op_b=%h expected valid=1 op_b=3", ex_valid, ex_op_b);
    else pass_cnt++;
`endif
    clear_producers();
    id_valid = 1'b0;
    tick();
    $display("[tb] priority rs2=3 resolved");
  endtask

  task automatic test_load_use();
    offer(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h130);
    tick();
    offer(5'd9, 5'd0, 5'd13, 1'b1, 1'b0, 32'h134);
    #1;
    total_cnt++;
    if (id_ready !== 1'b0) $display("FAIL lu_stall_ex: got %b expected 0", id_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0) $display("FAIL lu_bubble: got %b expected 0", ex_valid);
    else pass_cnt++;
    fwd_mem_rd = 5'd9; fwd_mem_wen = 1'b1; fwd_mem_is_load = 1'b1; fwd_mem_result = 32'h0;
    #1;
    total_cnt++;
    if (id_ready !== 1'b0) $display("FAIL lu_stall_mem: got %b expected 0", id_ready);
    else pass_cnt++;
    tick();
    clear_producers();
    fwd_wb_rd = 5'd9; fwd_wb_wen = 1'b1; fwd_wb_result = 32'hDEAD_0009;
    #1;
`ifdef OPFETCH_FORWARD_EN
    total_cnt++;
    if (id_ready !== 1'b1) $display("FAIL lu_accept: got %b expected 1", id_ready);
    else pass_cnt++;
    tick();
`else
    total_cnt++;
    if (id_ready !== 1'b0) $display("FAIL lu_stall_wb: got %b expected 0", id_ready);
    else pass_cnt++;
    tick();
    fwd_wb_wen = 1'b0;
    #1;
    total_cnt++;
    if (id_ready !== 1'b1) $display("FAIL lu_accept: got %b expected 1", id_ready);
    else pass_cnt++;
    tick();
`endif
    clear_producers();
    id_valid = 1'b0;
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_op_a !== 32'hDEAD_0009 || ex_rd !== 5'd13)
      $display("FAIL lu_op_a: got valid=%b op_a=%h rd=%0d expected valid=1 op_a=dead0009 rd=13",
               ex_valid, ex_op_a, ex_rd);
    else pass_cnt++;
    tick();
    $display("[tb] load-use rs1=9 -> op_a=%h", 32'hDEAD_0009);
  endtask

  task automatic test_backpressure_flush();
    offer(5'd5, 5'd0, 5'd14, 1'b1, 1'b0, 32'h200);
    tick();
    ex_ready = 1'b0;
    offer(5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 32'h300);
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++;
      if (id_ready !== 1'b0) $display("FAIL bp_id_ready[%0d]: got %b expected 0", c, id_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_op_a !== 32'h1234 || ex_rd !== 5'd14)
        $display("FAIL bp_hold[%0d]: got valid=%b pc=%h op_a=%h rd=%0d expected valid=1 pc=200 op_a=1234 rd=14",
                 c, ex_valid, ex_pc, ex_op_a, ex_rd);
      else pass_cnt++;
    end
    flush = 1'b1;
    #1;
    total_cnt++;
    if (id_ready !== 1'b0) $display("FAIL flush_id_ready: got %b expected 0", id_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0) $display("FAIL flush_ex_valid: got %b expected 0", ex_valid);
    else pass_cnt++;
    flush = 1'b0;
    ex_ready = 1'b1;
    id_valid = 1'b0;
    $display("[tb] backpressure 3 cycles then flush");
  endtask

  task automatic test_x0();
    fwd_wb_rd = 5'd0; fwd_wb_wen = 1'b1; fwd_wb_result = 32'h0000_FFFF;
    fwd_mem_rd = 5'd0; fwd_mem_wen = 1'b1; fwd_mem_is_load = 1'b1; fwd_mem_result = 32'h0000_EEEE;
    offer(5'd0, 5'd0, 5'd16, 1'b1, 1'b0, 32'h400);
    #1;
    total_cnt++;
    if (id_ready !== 1'b1) $display("FAIL x0_no_stall: got %b expected 1", id_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_op_a !== 32'h0 || ex_op_b !== 32'h0)
      $display("FAIL x0_operands: got valid=%b op_a=%h op_b=%h expected valid=1 op_a=0 op_b=0",
               ex_valid, ex_op_a, ex_op_b);
    else pass_cnt++;
    clear_producers();
    id_valid = 1'b0;
    tick();
    $display("[tb] x0 read -> op_a=0");
  endtask

  task automatic test_reset_mid_op();
    offer(5'd5, 5'd0, 5'd17, 1'b1, 1'b0, 32'h500);
    tick();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (id_ready !== 1'b0) $display("FAIL rst_mid_id_ready: got %b expected 0", id_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd0) 
      $display("FAIL rst_mid_discard: got valid=%b rd=%0d expected valid=0 rd=0", ex_valid, ex_rd);
    else pass_cnt++;
    rst = 1'b0;
    id_valid = 1'b0;
    tick();
    $display("[tb] reset mid-operation");
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    ex_ready = 1'b1;
    id_valid = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_rd_wen = 1'b0; id_is_load = 1'b0;
    id_pc = 32'h0; id_imm = 32'h0; id_ctrl = 16'h0;
    clear_producers();
    test_reset();
    test_regfile_read();
    test_wb_bypass();
    test_priority();
    test_load_use();
    test_backpressure_flush();
    test_x0();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
